cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares two Common Data Bus lanes among four result sources (FU1..FU3 and
//   the memory unit). Each source owns a one-entry holding register. Pending
//   entries are granted in round-robin order starting at r_rr. The first
//   pending entry goes to lane 1 and the second to lane 2. Lane payloads are
//   registered. The lanes have no backpressure.
//
// Ports
//   clk, rst              sole clock, synchronous active-high reset
//   flush                 synchronous squash from the ROB
//   req_valid_i           source i presents a result (i = 1..4)
//   req_ready_i           source i result is accepted on this edge if valid
//   req_ROBEN_i           destination ROB entry of source i
//   req_Write_Data_i      result value of source i
//   req_EXCEPTION_i       result of source i raised an exception
//   out_valid_j           CDB lane j carries a broadcast (j = 1..2)
//   out_ROBEN_j           lane j ROB entry (registered)
//   out_Write_Data_j      lane j result value (registered)
//   out_EXCEPTION_j       lane j exception flag (registered)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int ROB_SIZE_bits = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,

    input  logic                   req_valid_1,
    output logic                   req_ready_1,
    input  logic [ROB_SIZE_bits:0] req_ROBEN_1,
    input  logic [31:0]            req_Write_Data_1,
    input  logic                   req_EXCEPTION_1,

    input  logic                   req_valid_2,
    output logic                   req_ready_2,
    input  logic [ROB_SIZE_bits:0] req_ROBEN_2,
    input  logic [31:0]            req_Write_Data_2,
    input  logic                   req_EXCEPTION_2,

    input  logic                   req_valid_3,
    output logic                   req_ready_3,
    input  logic [ROB_SIZE_bits:0] req_ROBEN_3,
    input  logic [31:0]            req_Write_Data_3,
    input  logic                   req_EXCEPTION_3,

    input  logic                   req_valid_4,
    output logic                   req_ready_4,
    input  logic [ROB_SIZE_bits:0] req_ROBEN_4,
    input  logic [31:0]            req_Write_Data_4,
    input  logic                   req_EXCEPTION_4,

    output logic                   out_valid_1,
    output logic [ROB_SIZE_bits:0] out_ROBEN_1,
    output logic [31:0]            out_Write_Data_1,
    output logic                   out_EXCEPTION_1,

    output logic                   out_valid_2,
    output logic [ROB_SIZE_bits:0] out_ROBEN_2,
    output logic [31:0]            out_Write_Data_2,
    output logic                   out_EXCEPTION_2
);

    localparam int RW = ROB_SIZE_bits + 1;

    // Source-side inputs gathered into vectors, index 0 = source 1.
    logic [3:0]           w_vld;
    logic [3:0][RW-1:0]   w_rob;
    logic [3:0][31:0]     w_dat;
    logic [3:0]           w_exc;

    assign w_vld = {req_valid_4, req_valid_3, req_valid_2, req_valid_1};
    assign w_rob = {req_ROBEN_4, req_ROBEN_3, req_ROBEN_2, req_ROBEN_1};
    assign w_dat = {req_Write_Data_4, req_Write_Data_3, req_Write_Data_2, req_Write_Data_1};
    assign w_exc = {req_EXCEPTION_4, req_EXCEPTION_3, req_EXCEPTION_2, req_EXCEPTION_1};

    // Holding registers, round-robin pointer and lane registers.
    logic [3:0]           r_hv;
    logic [3:0][RW-1:0]   r_rob;
    logic [3:0][31:0]     r_dat;
    logic [3:0]           r_exc;
    logic [1:0]           r_rr;

    logic [1:0]           r_ov;
    logic [1:0][RW-1:0]   r_orob;
    logic [1:0][31:0]     r_odat;
    logic [1:0]           r_oexc;

    // Arbitration results.
    logic                 w_g1_vld;
    logic                 w_g2_vld;
    logic [1:0]           w_g1_idx;
    logic [1:0]           w_g2_idx;
    logic [1:0]           w_scan;
    logic [1:0]           w_rr_nxt;
    logic [3:0]           w_grant;
    logic [3:0]           w_rdy;
    logic [3:0]           w_acc;

    // Scan pending entries from r_rr upwards (mod 4). The first hit goes to
    // lane 1 and the second hit goes to lane 2.
    always_comb begin
        w_g1_vld = 1'b0;
        w_g2_vld = 1'b0;
        w_g1_idx = '0;
        w_g2_idx = '0;
        w_scan   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_scan = r_rr + k[1:0];
            if (r_hv[w_scan]) begin
                if (!w_g1_vld) begin
                    w_g1_vld = 1'b1;
                    w_g1_idx = w_scan;
                end else if (!w_g2_vld) begin
                    w_g2_vld = 1'b1;
                    w_g2_idx = w_scan;
                end
            end
        end

        w_grant = '0;
        if (w_g1_vld) w_grant[w_g1_idx] = 1'b1;
        if (w_g2_vld) w_grant[w_g2_idx] = 1'b1;

        // The pointer moves past the last source that was granted.
        if (w_g2_vld)      w_rr_nxt = w_g2_idx + 2'd1;
        else if (w_g1_vld) w_rr_nxt = w_g1_idx + 2'd1;
        else               w_rr_nxt = r_rr;
    end

    // Ready depends only on state, never on req_valid. A slot that is being
    // granted this edge can take a new result in the same edge.
    assign w_rdy = (~r_hv | w_grant) & {4{~(flush | rst)}};
    assign w_acc = w_vld & w_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hv   <= '0;
            r_rob  <= '0;
            r_dat  <= '0;
            r_exc  <= '0;
            r_rr   <= '0;
            r_ov   <= '0;
            r_orob <= '0;
            r_odat <= '0;
            r_oexc <= '0;
        end else if (flush) begin
            r_hv <= '0;
            r_ov <= '0;
            r_rr <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                // A new accept wins over the clear-on-grant.
                if (w_acc[i[1:0]]) begin
                    r_hv[i[1:0]]  <= 1'b1;
                    r_rob[i[1:0]] <= w_rob[i[1:0]];
                    r_dat[i[1:0]] <= w_dat[i[1:0]];
                    r_exc[i[1:0]] <= w_exc[i[1:0]];
                end else if (w_grant[i[1:0]]) begin
                    r_hv[i[1:0]] <= 1'b0;
                end
            end

            r_ov <= {w_g2_vld, w_g1_vld};
            if (w_g1_vld) begin
                r_orob[0] <= r_rob[w_g1_idx];
                r_odat[0] <= r_dat[w_g1_idx];
                r_oexc[0] <= r_exc[w_g1_idx];
            end
            if (w_g2_vld) begin
                r_orob[1] <= r_rob[w_g2_idx];
                r_odat[1] <= r_dat[w_g2_idx];
                r_oexc[1] <= r_exc[w_g2_idx];
            end
            r_rr <= w_rr_nxt;
        end
    end

    assign req_ready_1 = w_rdy[0];
    assign req_ready_2 = w_rdy[1];
    assign req_ready_3 = w_rdy[2];
    assign req_ready_4 = w_rdy[3];

    assign out_valid_1      = r_ov[0];
    assign out_ROBEN_1      = r_orob[0];
    assign out_Write_Data_1 = r_odat[0];
    assign out_EXCEPTION_1  = r_oexc[0];

    assign out_valid_2      = r_ov[1];
    assign out_ROBEN_2      = r_orob[1];
    assign out_Write_Data_2 = r_odat[1];
    assign out_EXCEPTION_2  = r_oexc[1];

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed vector table for cdb_arbiter (reset, single source, wrap,
//   continuous four-source load, grant-plus-accept, flush, reset with flush),
//   followed by a randomized run checked against per-source queues.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  vld = '0;
    logic [4:0]  rob [4];
    logic [31:0] dat [4];
    logic        exc [4];

    logic        req_ready_1, req_ready_2, req_ready_3, req_ready_4;
    logic        out_valid_1, out_valid_2;
    logic [4:0]  out_ROBEN_1, out_ROBEN_2;
    logic [31:0] out_Write_Data_1, out_Write_Data_2;
    logic        out_EXCEPTION_1, out_EXCEPTION_2;

    always #5 clk = ~clk;

    cdb_arbiter #(.ROB_SIZE_bits(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid_1(vld[0]), .req_ready_1(req_ready_1), .req_ROBEN_1(rob[0]),
        .req_Write_Data_1(dat[0]), .req_EXCEPTION_1(exc[0]),
        .req_valid_2(vld[1]), .req_ready_2(req_ready_2), .req_ROBEN_2(rob[1]),
        .req_Write_Data_2(dat[1]), .req_EXCEPTION_2(exc[1]),
        .req_valid_3(vld[2]), .req_ready_3(req_ready_3), .req_ROBEN_3(rob[2]),
        .req_Write_Data_3(dat[2]), .req_EXCEPTION_3(exc[2]),
        .req_valid_4(vld[3]), .req_ready_4(req_ready_4), .req_ROBEN_4(rob[3]),
        .req_Write_Data_4(dat[3]), .req_EXCEPTION_4(exc[3]),
        .out_valid_1(out_valid_1), .out_ROBEN_1(out_ROBEN_1),
        .out_Write_Data_1(out_Write_Data_1), .out_EXCEPTION_1(out_EXCEPTION_1),
        .out_valid_2(out_valid_2), .out_ROBEN_2(out_ROBEN_2),
        .out_Write_Data_2(out_Write_Data_2), .out_EXCEPTION_2(out_EXCEPTION_2)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, want %h", nm, row, act, exp);
        end
    endtask

    // Directed payload: source number in bits [11:8], ROB entry in low bits.
    function automatic logic [31:0] mkdat(input int s, input int r);
        return 32'hD000_0000 | (32'(s) << 8) | 32'(r);
    endfunction

    // One table row: inputs for a cycle, ready expected before the edge,
    // and the lanes expected after it (source 0 means the lane is idle).
    typedef struct {
        logic       rst;
        logic       flush;
        logic [3:0] v;
        int         r [4];
        logic [3:0] rdy;
        int         s1;
        int         e1;
        int         s2;
        int         e2;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic fl, input logic [3:0] v,
                                input int r1, input int r2, input int r3, input int r4,
                                input logic [3:0] rdy, input int s1, input int e1,
                                input int s2, input int e2);
        vec_t t;
        t.rst = rs; t.flush = fl; t.v = v;
        t.r[0] = r1; t.r[1] = r2; t.r[2] = r3; t.r[3] = r4;
        t.rdy = rdy; t.s1 = s1; t.e1 = e1; t.s2 = s2; t.e2 = e2;
        return t;
    endfunction

    task automatic lane_exp(input string nm, input int row, input logic ov,
                            input logic [4:0] orob, input logic [31:0] odat,
                            input logic oexc, input int s, input int e);
        logic [4:0] eb;
        chk({nm, "_valid"}, row, 32'(ov), (s != 0) ? 32'd1 : 32'd0);
        if (s != 0) begin
            eb = 5'(e);
            chk({nm, "_rob"}, row, 32'(orob), 32'(eb));
            chk({nm, "_data"}, row, odat, mkdat(s, e));
            chk({nm, "_exc"}, row, 32'(oexc), 32'(eb[0]));
        end
    endtask

    // Scoreboard for the randomized run.
    typedef struct {
        logic [4:0]  rob;
        logic [31:0] dat;
        logic        exc;
        int          cyc;
    } item_t;

    item_t sq [4][$];
    int    cyc = 0;
    int    n_in = 0;
    int    n_out = 0;
    int    n_drop = 0;

    task automatic pop_lane(input string nm, input logic ov, input logic [4:0] orob,
                            input logic [31:0] odat, input logic oexc);
        item_t it;
        int    s;
        if (!ov) return;
        s = int'(odat[17:16]);
        if (sq[s].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s unexpected broadcast at cycle %0d: got data %h, want none",
                     nm, cyc, odat);
        end else begin
            it = sq[s].pop_front();
            n_out++;
            chk({nm, "_rob"}, cyc, 32'(orob), 32'(it.rob));
            chk({nm, "_data"}, cyc, odat, it.dat);
            chk({nm, "_exc"}, cyc, 32'(oexc), 32'(it.exc));
            chk({nm, "_latency_ok"}, cyc, 32'((cyc - it.cyc) <= 2), 32'd1);
        end
    endtask

    task automatic lane_invariants();
        chk("lane2_without_lane1", cyc, 32'(out_valid_2 & ~out_valid_1), 32'd0);
        if (out_valid_1 && out_valid_2)
            chk("lanes_distinct_src", cyc,
                32'(out_Write_Data_1[17:16] != out_Write_Data_2[17:16]), 32'd1);
    endtask

    vec_t tbl [21];

    initial begin
        logic [3:0] rdyv;
        for (int i = 0; i < 4; i++) begin
            rob[i] = '0; dat[i] = '0; exc[i] = 1'b0;
        end

        //             rst  fl  v        r1 r2 r3 r4  rdy      s1 e1  s2 e2
        tbl[0]  = mk(1'b1, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b0000, 0, 0,  0, 0);
        tbl[1]  = mk(1'b0, 1'b0, 4'b0100,  0, 0, 5, 0, 4'b1111, 0, 0,  0, 0);
        tbl[2]  = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 3, 5,  0, 0);
        tbl[3]  = mk(1'b0, 1'b0, 4'b1001,  2, 0, 0, 7, 4'b1111, 0, 0,  0, 0);
        tbl[4]  = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 4, 7,  1, 2);
        tbl[5]  = mk(1'b0, 1'b0, 4'b1111,  8, 9,10,11, 4'b1111, 0, 0,  0, 0);
        tbl[6]  = mk(1'b0, 1'b0, 4'b1111, 12,13,14,15, 4'b0110, 2, 9,  3,10);
        tbl[7]  = mk(1'b0, 1'b0, 4'b1111, 16,17,18,19, 4'b1001, 4,11,  1, 8);
        tbl[8]  = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b0110, 2,13,  3,14);
        tbl[9]  = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 4,19,  1,16);
        tbl[10] = mk(1'b0, 1'b0, 4'b1111, 20,21,22,23, 4'b1111, 0, 0,  0, 0);
        tbl[11] = mk(1'b0, 1'b0, 4'b0010,  0,24, 0, 0, 4'b0110, 2,21,  3,22);
        tbl[12] = mk(1'b0, 1'b1, 4'b1111, 26,27,28,29, 4'b0000, 0, 0,  0, 0);
        tbl[13] = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 0,  0, 0);
        tbl[14] = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 0,  0, 0);
        tbl[15] = mk(1'b0, 1'b0, 4'b0011,  3, 4, 0, 0, 4'b1111, 0, 0,  0, 0);
        tbl[16] = mk(1'b1, 1'b1, 4'b1111,  5, 6, 7, 8, 4'b0000, 0, 0,  0, 0);
        tbl[17] = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 0,  0, 0);
        tbl[18] = mk(1'b0, 1'b0, 4'b0001, 30, 0, 0, 0, 4'b1111, 0, 0,  0, 0);
        tbl[19] = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1,30,  0, 0);
        tbl[20] = mk(1'b0, 1'b0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 0,  0, 0);

        for (int n = 0; n < 21; n++) begin
            @(negedge clk);
            rst   = tbl[n].rst;
            flush = tbl[n].flush;
            vld   = tbl[n].v;
            for (int i = 0; i < 4; i++) begin
                rob[i] = 5'(tbl[n].r[i]);
                dat[i] = mkdat(i + 1, tbl[n].r[i]);
                exc[i] = rob[i][0];
            end
            #1;
            rdyv = {req_ready_4, req_ready_3, req_ready_2, req_ready_1};
            chk("ready", n, 32'(rdyv), 32'(tbl[n].rdy));
            @(posedge clk);
            #1;
            lane_exp("lane1", n, out_valid_1, out_ROBEN_1, out_Write_Data_1,
                     out_EXCEPTION_1, tbl[n].s1, tbl[n].e1);
            lane_exp("lane2", n, out_valid_2, out_ROBEN_2, out_Write_Data_2,
                     out_EXCEPTION_2, tbl[n].s2, tbl[n].e2);
            if (n == 0) begin
                chk("reset_rob1", n, 32'(out_ROBEN_1), 32'd0);
                chk("reset_data1", n, out_Write_Data_1, 32'd0);
                chk("reset_exc1", n, 32'(out_EXCEPTION_1), 32'd0);
                chk("reset_rob2", n, 32'(out_ROBEN_2), 32'd0);
                chk("reset_data2", n, out_Write_Data_2, 32'd0);
                chk("reset_exc2", n, 32'(out_EXCEPTION_2), 32'd0);
            end
        end

        // Randomized run: random valids, occasional flush. Payload bits
        // [17:16] carry the source index and [15:0] a per-source sequence.
        begin
            int seq [4];
            logic fl;
            for (int i = 0; i < 4; i++) seq[i] = 0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                fl = ($urandom_range(0, 63) == 0);
                flush = fl;
                for (int i = 0; i < 4; i++) begin
                    vld[i] = 1'($urandom_range(0, 1));
                    rob[i] = 5'($urandom);
                    dat[i] = {8'hE5, 6'd0, 2'(i), 16'(seq[i])};
                    exc[i] = 1'($urandom_range(0, 1));
                end
                #1;
                rdyv = {req_ready_4, req_ready_3, req_ready_2, req_ready_1};
                if (fl) chk("stress_flush_ready", cyc, 32'(rdyv), 32'd0);
                @(posedge clk);
                cyc++;
                #1;
                if (fl) begin
                    for (int i = 0; i < 4; i++) begin
                        n_drop += sq[i].size();
                        sq[i].delete();
                    end
                    chk("stress_flush_lanes", cyc, 32'({out_valid_2, out_valid_1}), 32'd0);
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (vld[i] && rdyv[i]) begin
                            item_t it;
                            it.rob = rob[i]; it.dat = dat[i]; it.exc = exc[i]; it.cyc = cyc;
                            sq[i].push_back(it);
                            seq[i]++;
                            n_in++;
                        end
                    end
                    lane_invariants();
                    pop_lane("stress_lane1", out_valid_1, out_ROBEN_1, out_Write_Data_1, out_EXCEPTION_1);
                    pop_lane("stress_lane2", out_valid_2, out_ROBEN_2, out_Write_Data_2, out_EXCEPTION_2);
                end
            end

            // Drain with no new requests; every held result must come out.
            @(negedge clk);
            flush = 1'b0;
            vld   = '0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                cyc++;
                #1;
                lane_invariants();
                pop_lane("drain_lane1", out_valid_1, out_ROBEN_1, out_Write_Data_1, out_EXCEPTION_1);
                pop_lane("drain_lane2", out_valid_2, out_ROBEN_2, out_Write_Data_2, out_EXCEPTION_2);
            end
            for (int i = 0; i < 4; i++)
                chk("drain_queue_empty", i, 32'(sq[i].size()), 32'd0);
            chk("in_equals_out_plus_dropped", cyc, 32'(n_in), 32'(n_out + n_drop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
